// File: rtl/sipo_rx.sv
// Oversampled serial receiver: 8N1 / 8-bit-plus-parity frames to a byte.
// Bit timing advances only on i_sample_tick; outputs are registered.
module sipo_rx #(
  parameter int OSR         = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic       i_clk,
  input  logic       i_arst_n,
  input  logic       i_sample_tick,
  input  logic       i_rx,
  input  logic       i_par_en,
  input  logic       i_par_odd,
  output logic [7:0] o_data,
  output logic       o_data_valid,
  output logic       o_par_err,
  output logic       o_frame_err,
  output logic       o_busy
);

  localparam int TW = $clog2(OSR);
  localparam logic [TW-1:0] TICK_MID = TW'(OSR / 2 - 1);
  localparam logic [TW-1:0] TICK_END = TW'(OSR - 1);
  localparam logic [TW-1:0] TICK_ONE = TW'(1);
  localparam logic [TW-1:0] TICK_ZERO = TW'(0);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  function automatic logic f_xor8(input logic [7:0] d);
    return ^d;
  endfunction

  logic [SYNC_STAGES-1:0] r_sync;
  state_t                 r_state;
  logic [TW-1:0]          r_tick_cnt;
  logic [2:0]             r_bit_cnt;
  logic [7:0]             r_shift;
  logic                   r_par_en;
  logic                   r_par_odd;
  logic                   r_par_bit;
  logic                   r_armed;

  state_t        w_state_nxt;
  logic [TW-1:0] w_tick_nxt;
  logic [2:0]    w_bit_nxt;
  logic [7:0]    w_shift_nxt;
  logic          w_par_bit_nxt;
  logic          w_armed_nxt;
  logic          w_latch;
  logic          w_done;
  logic          w_rx_s;
  logic          w_par_err;

  assign w_rx_s    = r_sync[SYNC_STAGES-1];
  assign w_par_err = r_par_en & ((f_xor8(r_shift) ^ r_par_bit) != r_par_odd);

  // Next-state and counter/datapath update, evaluated only on sample ticks
  always_comb begin
    w_state_nxt   = r_state;
    w_tick_nxt    = r_tick_cnt;
    w_bit_nxt     = r_bit_cnt;
    w_shift_nxt   = r_shift;
    w_par_bit_nxt = r_par_bit;
    w_armed_nxt   = r_armed;
    w_latch       = 1'b0;
    w_done        = 1'b0;
    if (i_sample_tick) begin
      case (r_state)
        S_IDLE: begin
          if (w_rx_s) begin
            w_armed_nxt = 1'b1;
          end else if (r_armed) begin
            w_state_nxt = S_START;
            w_tick_nxt  = TICK_ZERO;
            w_latch     = 1'b1;
          end else begin
            w_armed_nxt = 1'b0;
          end
        end
        S_START: begin
          if (r_tick_cnt == TICK_MID) begin
            w_tick_nxt  = TICK_ZERO;
            w_state_nxt = w_rx_s ? S_IDLE : S_DATA;
          end else begin
            w_tick_nxt = r_tick_cnt + TICK_ONE;
          end
        end
        S_DATA: begin
          if (r_tick_cnt == TICK_END) begin
            w_tick_nxt  = TICK_ZERO;
            w_shift_nxt = {w_rx_s, r_shift[7:1]};
            if (r_bit_cnt == 3'd7) begin
              w_bit_nxt   = 3'd0;
              w_state_nxt = r_par_en ? S_PARITY : S_STOP;
            end else begin
              w_bit_nxt = r_bit_cnt + 3'd1;
            end
          end else begin
            w_tick_nxt = r_tick_cnt + TICK_ONE;
          end
        end
        S_PARITY: begin
          if (r_tick_cnt == TICK_END) begin
            w_tick_nxt    = TICK_ZERO;
            w_par_bit_nxt = w_rx_s;
            w_state_nxt   = S_STOP;
          end else begin
            w_tick_nxt = r_tick_cnt + TICK_ONE;
          end
        end
        S_STOP: begin
          if (r_tick_cnt == TICK_END) begin
            w_tick_nxt  = TICK_ZERO;
            w_state_nxt = S_IDLE;
            w_done      = 1'b1;
            // A low stop bit disarms start detection until the line is seen high.
            w_armed_nxt = w_rx_s;
          end else begin
            w_tick_nxt = r_tick_cnt + TICK_ONE;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_tick_nxt  = TICK_ZERO;
          w_bit_nxt   = 3'd0;
        end
      endcase
    end else begin
      w_state_nxt = r_state;
    end
  end

  // Line synchronizer, FSM state, counters and frame-local registers
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      r_sync     <= {SYNC_STAGES{1'b1}};
      r_state    <= S_IDLE;
      r_tick_cnt <= TICK_ZERO;
      r_bit_cnt  <= 3'd0;
      r_shift    <= 8'h00;
      r_par_en   <= 1'b0;
      r_par_odd  <= 1'b0;
      r_par_bit  <= 1'b0;
      r_armed    <= 1'b1;
    end else begin
      r_sync     <= {r_sync[SYNC_STAGES-2:0], i_rx};
      r_state    <= w_state_nxt;
      r_tick_cnt <= w_tick_nxt;
      r_bit_cnt  <= w_bit_nxt;
      r_shift    <= w_shift_nxt;
      r_par_bit  <= w_par_bit_nxt;
      r_armed    <= w_armed_nxt;
      if (w_latch) begin
        r_par_en  <= i_par_en;
        r_par_odd <= i_par_odd;
      end
    end
  end

  // Registered outputs; results land the cycle after the stop-bit sample
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      o_data       <= 8'h00;
      o_data_valid <= 1'b0;
      o_par_err    <= 1'b0;
      o_frame_err  <= 1'b0;
      o_busy       <= 1'b0;
    end else begin
      o_data_valid <= w_done;
      o_busy       <= (w_state_nxt != S_IDLE);
      if (w_done) begin
        o_data      <= r_shift;
        o_par_err   <= w_par_err;
        o_frame_err <= ~w_rx_s;
      end
    end
  end

endmodule

// File: doc/sipo_rx.md
SIPO_RX -- requirements
Module: sipo_rx

Interface
REQ-001 Parameter: OSR, 16, sample ticks per bit period (even, >=4).
REQ-002 Parameter: SYNC_STAGES, 2, flops in the i_rx synchronizer (>=2).
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-004 i_clk  input  1  system clock; all state changes on its rising edge.
REQ-005 i_arst_n  input  1  asynchronous active-low reset.
REQ-006 i_sample_tick  input  1  single-cycle enable at OSR x baud rate; all bit timing counts only these ticks.
REQ-007 i_rx  input  1  serial line; idle high; start bit, 8 data bits LSB first, optional parity, 1 stop bit.
REQ-008 i_par_en  input  1  1 = frame carries a parity bit between data and stop.
REQ-009 i_par_odd  input  1  0 = even parity expected, 1 = odd.
REQ-010 o_data  output  8  last received byte.
REQ-011 o_data_valid  output  1  one-cycle pulse: o_data and error flags are updated this cycle.
REQ-012 o_par_err  output  1  parity mismatch in last frame (0 when parity disabled).
REQ-013 o_frame_err  output  1  stop bit sampled low in last frame.
REQ-014 o_busy  output  1  high in every state except IDLE.

Function
REQ-015 i_rx SHALL pass through a SYNC_STAGES flop synchronizer reset to 1; all sampling uses the synchronized value (rx_s).
REQ-016 FSM states SHALL be IDLE, START, DATA, PARITY, STOP.
REQ-017 A tick counter (0..OSR-1) and a bit counter (0..7) SHALL advance only when i_sample_tick is high.
REQ-018 IDLE: on a tick with rx_s = 0, go to START, tick counter cleared; latch i_par_en and i_par_odd for the whole frame.
REQ-019 START: at tick count OSR/2-1 (mid start bit), rx_s = 0 -> DATA with tick counter cleared; rx_s = 1 -> IDLE (false start, no pulse, flags unchanged).
REQ-020 DATA: at each tick count OSR-1, sample rx_s into the shift register MSB, shifting right (LSB first); after the 8th sample go to PARITY if latched par_en, else STOP.
REQ-021 PARITY: at tick count OSR-1, sample the parity bit; error = (XOR of 8 data bits XOR parity bit) != latched par_odd.
REQ-022 STOP: at tick count OSR-1, sample the stop bit; frame error = (rx_s == 0); go to IDLE.
REQ-023 o_data, o_par_err, o_frame_err SHALL update, and o_data_valid pulse high for exactly one i_clk cycle, in the cycle after the stop-bit sampling tick.
REQ-024 o_data_valid SHALL fire even when errors are flagged; flags hold until the next o_data_valid.
REQ-025 After a frame error, IDLE SHALL NOT accept a new start until rx_s has been sampled high on at least one tick (no re-trigger on a held-low line/break).
REQ-026 Ticks arriving while i_sample_tick-qualified sampling is pending SHALL never be double-counted; gaps between ticks of any length SHALL only stretch timing.
REQ-027 Changes to i_par_en/i_par_odd mid-frame SHALL NOT affect the frame in progress.

Reset
REQ-028 Reset assertion SHALL immediately (asynchronously) force IDLE, counters 0, shift register 0, synchronizer to 1.
REQ-029 Reset values: o_data = 8'h00, o_data_valid = 0, o_par_err = 0, o_frame_err = 0, o_busy = 0.
REQ-030 Reset mid-frame SHALL discard the partial byte with no o_data_valid pulse; the first start bit after release is received normally.

Verification
REQ-031 Frame 8'hA5, par_en=0, stop=1, OSR=16 -> one o_data_valid pulse, o_data=8'hA5, both errors 0, o_busy high from start detect to pulse.
REQ-032 Frame 8'h03, par_en=1, par_odd=0, parity bit 0 -> o_data=8'h03, o_par_err=0; repeat with parity bit 1 -> o_par_err=1.
REQ-033 Frame 8'h5A with stop bit 0, line then held low 40 bit times -> o_data=8'h5A, o_frame_err=1, no further pulse until line returns high and a new start bit arrives.
REQ-034 i_rx low for 4 ticks then high -> back to IDLE, no o_data_valid, outputs unchanged.
REQ-035 Reset asserted during data bit 4 of a frame, released, then frame 8'hFF sent -> no pulse for the aborted frame; next pulse has o_data=8'hFF, errors 0.
REQ-036 Back-to-back frames 8'h00 then 8'hFF with no idle gap, irregular tick spacing -> two pulses, correct data, errors 0.
